crc_serial_lfsr: RTL and testbench
==================================

// Module: crc_serial_lfsr
// PURPOSE
//  Bit-serial CRC generator for the low-power comms subsystem. It folds a serial DATA stream into a WIDTH-bit
//  Galois LFSR while Active is high. When Active falls, it shifts the CRC out serially (LSB first) with Valid asserted.
//  Sits between the serial framer and the line driver.
// PARAMETERS
//  WIDTH      8       CRC/LFSR width in bits
//  SEED       8'hD8   LFSR value after reset and at the start of every frame
//  POLY_MASK  8'hC4   XOR mask applied after right shift when feedback=1 (bit WIDTH-1 must be set)
// PORTS
//  CLK     input   1  single clock, all state on rising edge
//  rst_n   input   1  reset, asynchronous, active-low
//  DATA    input   1  serial message bit, sampled on CLK rise while Active=1
//  Active  input   1  high = message bits present; falling edge ends the frame
//  CRC     output  1  serial CRC bit, registered, meaningful only when Valid=1
//  Valid   output  1  high for exactly WIDTH cycles while CRC bits are driven
// BEHAVIOUR
//  - Reset (async, rst_n=0): LFSR=SEED, CRC=0, Valid=0, bit counter=0, state=IDLE.
//  - States: IDLE, CALC, OUT (enum in package).
//  - IDLE: Active=1 at an edge -> absorb DATA that edge, go to CALC. Active=0 -> stay; no output ever without data.
//  - CALC, each edge with Active=1: fb=DATA^LFSR[0]; LFSR <= (LFSR>>1) ^ (fb ? POLY_MASK : 0).
//    With defaults: LFSR7<=fb, LFSR6<=LFSR7^fb, LFSR2<=LFSR3^fb, other bits shift right.
//  - CALC, first edge with Active=0: CRC<=LFSR[0], Valid<=1, LFSR<=LFSR>>1 (zero fill), counter<=1, go to OUT.
//    Latency: first CRC bit is visible one edge after the last data bit.
//  - OUT: each edge with counter<WIDTH: CRC<=LFSR[0], shift, counter++.
//    At counter==WIDTH: Valid<=0, CRC<=0, LFSR<=SEED, counter<=0, go to IDLE.
//  - Active during OUT is ignored (its DATA bits are dropped). The next frame starts only from IDLE.
//  - Counter width is clog2(WIDTH+1) and never wraps. Valid is never high for more or fewer than WIDTH cycles.
//  - rst_n low mid-CALC or mid-OUT: immediate return to reset values; partial CRC is discarded.
//  - DATA is don't-care when Active=0.
// CONFIGURATION
//  CRC_DONE_PULSE_EN defined: extra output Done (1 bit) pulses high for one cycle on the edge where Valid falls.
//    Done resets to 0.
//  CRC_DONE_PULSE_EN undefined: no Done port; behaviour otherwise identical.
// STRUCTURE
//  Package crc_serial_pkg: state enum (IDLE/CALC/OUT), default WIDTH, SEED, POLY_MASK constants.
//  Sub-module crc_lfsr_core: LFSR register with load-seed, absorb (fb from DATA) and shift-out (zero fill) controls.
//  Top: FSM, bit counter, CRC/Valid registers.
// TESTING
//  1. Reset 3 cycles, Active=0 for 10 cycles -> Valid stays 0, CRC stays 0.
//  2. 8 bits DATA=0 with Active=1, then Active=0 -> LFSR=0x14.
//     Valid high 8 cycles; CRC sequence 0,0,1,0,1,0,0,0.
//  3. Single bit DATA=1, then Active=0 -> LFSR=0xA8; CRC sequence 0,0,0,1,0,1,0,1.
//  4. 16 random bits, then Active=0 for 20 cycles.
//     -> CRC matches the reference model; Valid exactly 8 cycles; back to IDLE with LFSR=0xD8.
//  5. Assert rst_n=0 at output bit 3 -> Valid/CRC drop to 0 immediately.
//     A following 8-zero frame again yields 0x14.
//  6. Pulse Active during OUT -> output unchanged. With CRC_DONE_PULSE_EN: Done high exactly 1 cycle as Valid falls.

Source files
------------

// File: rtl/crc_serial_pkg.sv
// Shared types and default constants for the bit-serial CRC generator.
package crc_serial_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StOut
    } state_e;

    localparam int unsigned DefWidth    = 8;
    localparam logic [7:0]  DefSeed     = 8'hD8;
    localparam logic [7:0]  DefPolyMask = 8'hC4;

endpackage

// File: rtl/crc_lfsr_core.sv
// Galois LFSR register: seed load, data absorb and zero-fill shift-out.
module crc_lfsr_core
    import crc_serial_pkg::*;
#(
    parameter int unsigned      WIDTH     = DefWidth,
    parameter logic [WIDTH-1:0] SEED      = DefSeed,
    parameter logic [WIDTH-1:0] POLY_MASK = DefPolyMask
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_seed_i,
    input  logic absorb_i,
    input  logic shift_i,
    input  logic data_i,
    output logic lsb_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic             fb;

    assign fb    = data_i ^ lfsr_q[0];
    assign lsb_o = lfsr_q[0];

    // Seed load wins so a frame boundary always restarts from a known value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (load_seed_i) begin
            lfsr_q <= SEED;
        end else if (absorb_i) begin
            lfsr_q <= (lfsr_q >> 1) ^ (fb ? POLY_MASK : '0);
        end else if (shift_i) begin
            lfsr_q <= lfsr_q >> 1;
        end
    end

endmodule

// File: rtl/crc_serial_lfsr.sv
// Bit-serial CRC generator: absorbs DATA while Active, then emits the CRC LSB first.
// Optional Done pulse on the Valid falling edge when CRC_DONE_PULSE_EN is defined.
module crc_serial_lfsr
    import crc_serial_pkg::*;
#(
    parameter int unsigned      WIDTH     = DefWidth,
    parameter logic [WIDTH-1:0] SEED      = DefSeed,
    parameter logic [WIDTH-1:0] POLY_MASK = DefPolyMask
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic DATA,
    input  logic Active,
    output logic CRC,
    output logic Valid
`ifdef CRC_DONE_PULSE_EN
    ,
    output logic Done
`endif
);

    localparam int unsigned     CntW   = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            crc_q;
    logic            valid_q;
    logic            done_q;

    logic lfsr_lsb;
    logic load_seed;
    logic absorb;
    logic shift;

    always_comb begin
        absorb    = 1'b0;
        shift     = 1'b0;
        load_seed = 1'b0;
        unique case (state_q)
            StIdle: absorb = Active;
            StCalc: begin
                absorb = Active;
                shift  = !Active;
            end
            StOut: begin
                shift     = (cnt_q < CntMax);
                load_seed = (cnt_q == CntMax);
            end
            default: ;
        endcase
    end

    crc_lfsr_core #(
        .WIDTH    (WIDTH),
        .SEED     (SEED),
        .POLY_MASK(POLY_MASK)
    ) u_core (
        .clk        (CLK),
        .rst_n      (rst_n),
        .load_seed_i(load_seed),
        .absorb_i   (absorb),
        .shift_i    (shift),
        .data_i     (DATA),
        .lsb_o      (lfsr_lsb)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            crc_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Active) state_q <= StCalc;
                end
                StCalc: begin
                    if (!Active) begin
                        crc_q   <= lfsr_lsb;
                        valid_q <= 1'b1;
                        cnt_q   <= CntW'(1);
                        state_q <= StOut;
                    end
                end
                StOut: begin
                    // Active is ignored here; a new frame can only start from idle.
                    if (cnt_q < CntMax) begin
                        crc_q <= lfsr_lsb;
                        cnt_q <= cnt_q + CntW'(1);
                    end else begin
                        crc_q   <= 1'b0;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign CRC   = crc_q;
    assign Valid = valid_q;

`ifdef CRC_DONE_PULSE_EN
    assign Done = done_q;
`else
    logic unused_done;
    assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_crc_serial_lfsr.sv
// Self-checking bench for crc_serial_lfsr against a bit-level CRC reference model.
module tb_crc_serial_lfsr;

    logic CLK;
    logic rst_n;
    logic DATA;
    logic Active;
    logic CRC;
    logic Valid;
`ifdef CRC_DONE_PULSE_EN
    logic Done;
`endif

    int tests_run;
    int tests_failed;

    crc_serial_lfsr dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .DATA  (DATA),
        .Active(Active),
        .CRC   (CRC),
        .Valid (Valid)
`ifdef CRC_DONE_PULSE_EN
        ,
        .Done  (Done)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: fold each bit into the register value as an integer.
    function automatic logic [7:0] ref_crc(input logic [31:0] bits, input int n);
        int r;
        int fb;
        r = 'hD8;
        for (int i = 0; i < n; i++) begin
            fb = int'(bits[i]) ^ (r % 2);
            r  = r / 2;
            if (fb != 0) r = r ^ 'hC4;
        end
        return r[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; drives n data bits then drops Active.
    task automatic send_frame(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            Active = 1'b1;
            DATA   = bits[i];
            @(negedge CLK);
        end
        Active = 1'b0;
        DATA   = 1'($urandom);
    endtask

    // Collects WIDTH output bits; optionally wiggles inputs or resets after bit reset_at.
    task automatic collect(input logic [7:0] exp, input string tag, input bit wiggle,
                           input int reset_at);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check({tag, "_valid"}, 32'(Valid), 32'd1);
            check({tag, "_crc"}, 32'(CRC), 32'(exp[i]));
`ifdef CRC_DONE_PULSE_EN
            check({tag, "_done_low"}, 32'(Done), 32'd0);
`endif
            if (i == reset_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_valid"}, 32'(Valid), 32'd0);
                check({tag, "_rst_crc"}, 32'(CRC), 32'd0);
                Active = 1'b0;
                @(negedge CLK);
                check({tag, "_rst_hold"}, 32'(Valid), 32'd0);
                rst_n = 1'b1;
                return;
            end
            if (wiggle) begin
                Active = 1'($urandom);
                DATA   = 1'($urandom);
            end
        end
        Active = 1'b0;
        @(negedge CLK);
        check({tag, "_valid_fall"}, 32'(Valid), 32'd0);
        check({tag, "_crc_zero"}, 32'(CRC), 32'd0);
`ifdef CRC_DONE_PULSE_EN
        check({tag, "_done_pulse"}, 32'(Done), 32'd1);
`endif
        @(negedge CLK);
        check({tag, "_idle_valid"}, 32'(Valid), 32'd0);
`ifdef CRC_DONE_PULSE_EN
        check({tag, "_done_clear"}, 32'(Done), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] bits;
        int          n;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        DATA         = 1'b0;
        Active       = 1'b0;

        // Reset held for three cycles, then idle with no data.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("reset_valid", 32'(Valid), 32'd0);
            check("reset_crc", 32'(CRC), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            DATA = 1'($urandom);
            @(negedge CLK);
            check("idle_valid", 32'(Valid), 32'd0);
            check("idle_crc", 32'(CRC), 32'd0);
        end

        // Eight zero bits: known CRC 0x14.
        send_frame(32'h0, 8);
        collect(8'h14, "zeros8", 1'b0, -1);

        // Single one bit: known CRC 0xA8.
        send_frame(32'h1, 1);
        collect(8'hA8, "one1", 1'b0, -1);

        // Sixteen random bits, then a long idle stretch.
        bits = $urandom & 32'hFFFF;
        send_frame(bits, 16);
        collect(ref_crc(bits, 16), "rand16", 1'b0, -1);
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            check("rand16_idle", 32'(Valid), 32'd0);
        end
        send_frame(32'h0, 8);
        collect(8'h14, "reseed", 1'b0, -1);

        // Reset in the middle of output, then a clean zero frame.
        send_frame(32'h0, 8);
        collect(8'h14, "midrst", 1'b0, 3);
        send_frame(32'h0, 8);
        collect(8'h14, "after_rst", 1'b0, -1);

        // Active and DATA toggling during output must not disturb it.
        bits = $urandom;
        send_frame(bits, 12);
        collect(ref_crc(bits, 12), "wiggle", 1'b1, -1);

        // Random lengths, including the spec's own reference-model check.
        for (int k = 0; k < 6; k++) begin
            bits = $urandom;
            n    = int'($urandom_range(1, 32));
            send_frame(bits, n);
            collect(ref_crc(bits, n), "randlen", 1'(k % 2), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
